// File: rtl/auto_gated_register_bank.sv
// auto_gated_register_bank
//  NUM_BANKS independent WIDTH-bit storage registers. Each register sits behind
//  its own latch-based clock gate controlled by an idle-detect FSM: after
//  IDLE_CYCLES consecutive cycles without a write the bank clock is switched
//  off. A write request (or gate_disable) reopens the clock, and the write is
//  accepted once a WAKE_CYCLES settle window has elapsed.
//
//  Optional feature macro: GATE_STATS_EN
//   When defined, a STAT_W saturating counter per bank counts clk cycles spent
//   in the gated state and is exported on gated_cycles (same packing as data).
//   When undefined, the parameter, port and counters do not exist.
//
//  Reset is synchronous and active-high. The FSM, idle/wake counters and stats
//  run on clk; the data registers run on the per-bank gated clock.
`timescale 1ns/1ps
module auto_gated_register_bank #(
  parameter int WIDTH       = 8,
  parameter int NUM_BANKS   = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
`ifdef GATE_STATS_EN
  ,
  parameter int STAT_W      = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gate_disable,
  input  logic [NUM_BANKS-1:0]        wr_valid,
  output logic [NUM_BANKS-1:0]        wr_ready,
  input  logic [NUM_BANKS*WIDTH-1:0]  wr_data,
  output logic [NUM_BANKS*WIDTH-1:0]  data_out,
  output logic [NUM_BANKS-1:0]        bank_gated
`ifdef GATE_STATS_EN
  ,
  output logic [NUM_BANKS*STAT_W-1:0] gated_cycles
`endif
);

  // Counters only ever hold 0 .. N-1, so $clog2(N) bits suffice (min 1 bit).
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,  // clock running, writes accepted
    ST_GATED  = 2'b01,  // clock off, contents held
    ST_WAKING = 2'b10   // clock running again, settling before accepting writes
  } state_t;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank

    state_t            state;
    state_t            state_nx;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nx;
    logic [WAKE_W-1:0] wake_cnt;
    logic [WAKE_W-1:0] wake_nx;
    logic              ready_raw;
    logic              gate_en;
    logic              en_latched;
    logic              gclk;
    logic [WIDTH-1:0]  data_q;

    // Next-state, counter updates and per-state outputs for this bank.
    always_comb begin
      // NOTE: every output of this block gets a default before the case, so
      // no path leaves a variable unassigned and no latch is inferred here.
      state_nx  = state;
      idle_nx   = idle_cnt;
      wake_nx   = wake_cnt;
      ready_raw = 1'b0;
      unique case (state)
        ST_ACTIVE: begin
          ready_raw = 1'b1;
          if (wr_valid[b]) begin
            // A write on the final idle cycle also lands here: no gating.
            idle_nx = '0;
          end else if (gate_disable) begin
            idle_nx = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_nx = ST_GATED;
            idle_nx  = '0;
          end else begin
            idle_nx = idle_cnt + IDLE_W'(1);
          end
        end
        ST_GATED: begin
          // Either cause (or both together) yields one WAKING entry.
          if (wr_valid[b] || gate_disable) begin
            state_nx = ST_WAKING;
            wake_nx  = '0;
          end
        end
        ST_WAKING: begin
          if (wake_cnt == WAKE_LAST) begin
            state_nx = ST_ACTIVE;
            idle_nx  = '0;
            wake_nx  = '0;
          end else begin
            wake_nx = wake_cnt + WAKE_W'(1);
          end
        end
        default: begin
          state_nx = ST_ACTIVE;
          idle_nx  = '0;
          wake_nx  = '0;
        end
      endcase
    end

    // FSM state and idle/wake counters on the free-running clock.
    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // the design samples pre-edge values regardless of evaluation order.
      if (reset) begin
        state    <= ST_ACTIVE;
        idle_cnt <= '0;
        wake_cnt <= '0;
      end else begin
        state    <= state_nx;
        idle_cnt <= idle_nx;
        wake_cnt <= wake_nx;
      end
    end

    // Clock stays enabled outside GATED, and is forced on during reset so the
    // synchronous reset can reach the data register of a gated bank.
    assign gate_en = (state != ST_GATED) || reset;

    // Integrated clock gate: enable is captured while clk is low.
    always_latch begin
      // NOTE: this latch is intentional. Holding the enable stable through the
      // high phase keeps gclk free of glitches and truncated pulses.
      if (!clk) begin
        en_latched <= gate_en;
      end
    end

    assign gclk = clk & en_latched;

    // Bank storage on the gated clock; writes land one edge after acceptance.
    always_ff @(posedge gclk) begin
      // NOTE: the stored data is reset (not left undefined); that only works
      // because gate_en is forced high while reset is asserted.
      if (reset) begin
        data_q <= '0;
      end else if (state == ST_ACTIVE && wr_valid[b]) begin
        data_q <= wr_data[b*WIDTH +: WIDTH];
      end
    end

    assign wr_ready[b]                   = ready_raw & ~reset;
    assign bank_gated[b]                 = (state == ST_GATED);
    assign data_out[b*WIDTH +: WIDTH]    = data_q;

`ifdef GATE_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // Saturating count of clk cycles spent gated; cleared only by reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        stat_q <= '0;
      end else if (state == ST_GATED && stat_q != '1) begin
        stat_q <= stat_q + STAT_W'(1);
      end
    end

    assign gated_cycles[b*STAT_W +: STAT_W] = stat_q;
`endif

  end : g_bank

endmodule

// File: tb/tb_auto_gated_register_bank.sv
// tb_auto_gated_register_bank
//  Directed bench for auto_gated_register_bank with IDLE_CYCLES=4,
//  WAKE_CYCLES=2. Inputs change 2 ns after a rising edge; outputs are
//  checked at that same point, away from the edge. Each cycle Cn lies
//  between rising edges En and En+1.
`timescale 1ns/1ps
module tb_auto_gated_register_bank;

  localparam int WIDTH = 8;
  localparam int NB    = 4;
  localparam int IDLE  = 4;
  localparam int WAKE  = 2;
`ifdef GATE_STATS_EN
  localparam int STAT_W = 16;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                gate_disable;
  logic [NB-1:0]       wr_valid;
  logic [NB-1:0]       wr_ready;
  logic [NB*WIDTH-1:0] wr_data;
  logic [NB*WIDTH-1:0] data_out;
  logic [NB-1:0]       bank_gated;
`ifdef GATE_STATS_EN
  logic [NB*STAT_W-1:0] gated_cycles;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic ever_gated;

  always #5 clk = ~clk;

  auto_gated_register_bank #(
    .WIDTH       (WIDTH),
    .NUM_BANKS   (NB),
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (WAKE)
`ifdef GATE_STATS_EN
    ,
    .STAT_W      (STAT_W)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gate_disable (gate_disable),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .data_out     (data_out),
    .bank_gated   (bank_gated)
`ifdef GATE_STATS_EN
    ,
    .gated_cycles (gated_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int b, input logic [WIDTH-1:0] v);
    wr_data[b*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [WIDTH-1:0] bank_data(input int b);
    return data_out[b*WIDTH +: WIDTH];
  endfunction

  // Two reset edges, then release; returns in cycle C0 with all banks ACTIVE.
  task automatic apply_reset();
    reset        = 1'b1;
    wr_valid     = '0;
    gate_disable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    gate_disable = 1'b0;
    wr_valid     = '0;
    wr_data      = '0;

    // ---- Scenario 1: reset state, first write with latency 1 ----
    tick();
    tick();
    check("rst_ready", 32'(wr_ready), 32'h0);
    check("rst_gated", 32'(bank_gated), 32'h0);
    check("rst_data", data_out, 32'h0);
    reset = 1'b0;
    set_data(0, 8'hAA);
    wr_valid = 4'b0001;
    #1;
    check("rel_ready", 32'(wr_ready), 32'hF);
    tick();
    wr_valid = '0;
    check("s1_data_b0", 32'(bank_data(0)), 32'hAA);
    check("s1_data_rest", 32'(data_out[31:8]), 32'h0);

    // ---- Scenario 2: idle bank 1 gates after 4 idle cycles ----
    apply_reset();
    check("s2_rst_clear_b0", 32'(bank_data(0)), 32'h0);
    repeat (3) tick();
    check("s2_not_yet", 32'(bank_gated[1]), 32'h0);
    tick();
    check("s2_gated_b1", 32'(bank_gated[1]), 32'h1);
    check("s2_ready_b1", 32'(wr_ready[1]), 32'h0);
    check("s2_all_gated", 32'(bank_gated), 32'hF);
    repeat (6) tick();
    check("s2_hold_b1", 32'(bank_data(1)), 32'h0);
`ifdef GATE_STATS_EN
    check("s2_stat_b1", 32'(gated_cycles[1*STAT_W +: STAT_W]), 32'd6);
`endif

    // ---- Scenario 3: wake banks 1 and 0 together, held request ----
    set_data(1, 8'h55);
    set_data(0, 8'h3C);
    wr_valid = 4'b0011;
    #1;
    check("s3_c0_ready", 32'(wr_ready[1:0]), 32'h0);
    tick();
    check("s3_c1_ready", 32'(wr_ready[1:0]), 32'h0);
    check("s3_c1_gated", 32'(bank_gated[1:0]), 32'h0);
    tick();
    check("s3_c2_ready", 32'(wr_ready[1:0]), 32'h0);
    tick();
    check("s3_c3_ready", 32'(wr_ready[1:0]), 32'h3);
    check("s3_c3_nowrite", 32'(bank_data(1)), 32'h0);
`ifdef GATE_STATS_EN
    check("s3_stat_b1", 32'(gated_cycles[1*STAT_W +: STAT_W]), 32'd7);
`endif
    tick();
    wr_valid = '0;
    check("s3_data_b1", 32'(bank_data(1)), 32'h55);
    check("s3_data_b0", 32'(bank_data(0)), 32'h3C);
    check("s3_ungated", 32'(bank_gated[1:0]), 32'h0);

    // ---- Scenario 6: reset during WAKING of bank 1 ----
    repeat (4) tick();
    check("s6_gated", 32'(bank_gated[1:0]), 32'h3);
    set_data(1, 8'h77);
    wr_valid = 4'b0010;
    tick();
    check("s6_waking", {30'h0, bank_gated[1], wr_ready[1]}, 32'h0);
    check("s6_hold_b1", 32'(bank_data(1)), 32'h55);
    reset = 1'b1;
    #1;
    check("s6_ready_in_rst", 32'(wr_ready), 32'h0);
    tick();
    check("s6_data_b1", 32'(bank_data(1)), 32'h0);
    check("s6_data_b0_gated", 32'(bank_data(0)), 32'h0);
    check("s6_gated", 32'(bank_gated), 32'h0);
`ifdef GATE_STATS_EN
    check("s6_stat", gated_cycles[31:0], 32'h0);
    check("s6_stat_hi", gated_cycles[63:32], 32'h0);
`endif
    reset    = 1'b0;
    wr_valid = '0;
    #1;
    check("s6_rel_ready", 32'(wr_ready), 32'hF);

    // ---- Scenario 4: bank 2 written on its final idle cycle ----
    apply_reset();
    ever_gated = 1'b0;
    for (int n = 0; n < 40; n++) begin
      set_data(2, 8'(n));
      wr_valid = (n % 4 == 3) ? 4'b0100 : 4'b0000;
      tick();
      ever_gated = ever_gated | bank_gated[2];
    end
    wr_valid = '0;
    check("s4_never_gated", 32'(ever_gated), 32'h0);
    check("s4_data_b2", 32'(bank_data(2)), 32'd39);
    check("s4_others_gated", 32'(bank_gated), 32'hB);

    // ---- Scenario 5: gate_disable wakes and holds, then re-gating ----
    gate_disable = 1'b1;
    #1;
    check("s5_c0_gated", 32'(bank_gated[3]), 32'h1);
    tick();
    check("s5_wake0", {30'h0, bank_gated[3], wr_ready[3]}, 32'h0);
    tick();
    check("s5_wake1_ready", 32'(wr_ready[3]), 32'h0);
    tick();
    check("s5_active_ready", 32'(wr_ready[3]), 32'h1);
    ever_gated = 1'b0;
    repeat (17) begin
      tick();
      ever_gated = ever_gated | bank_gated[3];
    end
    check("s5_stay_ungated", 32'(ever_gated), 32'h0);
    check("s5_all_ungated", 32'(bank_gated), 32'h0);
    gate_disable = 1'b0;
    repeat (3) tick();
    check("s5_pre_regate", 32'(bank_gated), 32'h0);
    tick();
    check("s5_regated", 32'(bank_gated), 32'hF);

    // ---- Scenario 7: gate_disable and wr_valid together in GATED ----
    gate_disable = 1'b1;
    set_data(0, 8'h5A);
    wr_valid = 4'b0001;
    #1;
    check("s7_c0_ready", 32'(wr_ready[0]), 32'h0);
    tick();
    tick();
    check("s7_c2_ready", 32'(wr_ready[0]), 32'h0);
    tick();
    check("s7_c3_ready", 32'(wr_ready[0]), 32'h1);
    tick();
    wr_valid     = '0;
    gate_disable = 1'b0;
    check("s7_data_b0", 32'(bank_data(0)), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
